oldland_memory: RTL

OLDLAND_MEMORY -- requirements
Module: oldland_memory

---
 rtl/oldland_memory.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/oldland_memory.sv
// Load/store unit for the Oldland pipeline: one data-bus transaction per
// memory op, little-endian lane steering, alignment aborts and writeback.
module oldland_memory (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_load,
    input  logic        mem_store,
    input  logic [1:0]  mem_width,
    input  logic [31:0] mar,
    input  logic [31:0] mdr,
    input  logic        wr_result,
    input  logic [3:0]  rd_sel,
    input  logic [31:0] wr_val,
    output logic [31:0] d_addr,
    output logic [3:0]  d_bytesel,
    output logic        d_wr_en,
    output logic [31:0] d_wr_val,
    output logic        d_access,
    input  logic [31:0] d_data,
    input  logic        d_ack,
    input  logic        d_error,
    output logic        busy,
    output logic        data_abort,
    output logic        reg_wr_en,
    output logic [3:0]  reg_wr_sel,
    output logic [31:0] reg_wr_val
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;

    state_t      state_q, state_d;
    logic        d_access_q, d_access_d;
    logic [31:0] d_addr_q, d_addr_d;
    logic [3:0]  d_bytesel_q, d_bytesel_d;
    logic        d_wr_en_q, d_wr_en_d;
    logic [31:0] d_wr_val_q, d_wr_val_d;
    logic        data_abort_q, data_abort_d;
    logic        reg_wr_en_q, reg_wr_en_d;
    logic [3:0]  reg_wr_sel_q, reg_wr_sel_d;
    logic [31:0] reg_wr_val_q, reg_wr_val_d;

    logic        mem_op;
    logic        misaligned;
    logic [3:0]  bytesel;
    logic [31:0] store_val;
    logic [31:0] load_shifted;
    logic [31:0] load_val;

    assign mem_op = mem_load | mem_store;

    // Lane steering and alignment; the reserved width 2'b11 falls into the word arms.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so no latch is inferred.
        misaligned   = 1'b0;
        bytesel      = 4'b1111;
        store_val    = mdr;
        load_shifted = d_data >> {mar[1:0], 3'b000};
        load_val     = load_shifted;
        case (mem_width)
            WIDTH_BYTE: begin
                bytesel   = 4'b0001 << mar[1:0];
                store_val = {4{mdr[7:0]}};
                load_val  = {24'd0, load_shifted[7:0]};
            end
            WIDTH_HALF: begin
                misaligned = mar[0];
                bytesel    = 4'b0011 << mar[1:0];
                store_val  = {2{mdr[15:0]}};
                load_val   = {16'd0, load_shifted[15:0]};
            end
            default: misaligned = (mar[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        state_d      = state_q;
        d_access_d   = d_access_q;
        d_addr_d     = d_addr_q;
        d_bytesel_d  = d_bytesel_q;
        d_wr_en_d    = d_wr_en_q;
        d_wr_val_d   = d_wr_val_q;
        data_abort_d = 1'b0;
        reg_wr_en_d  = 1'b0;
        reg_wr_sel_d = reg_wr_sel_q;
        reg_wr_val_d = reg_wr_val_q;
        busy         = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    busy = 1'b1;
                    if (misaligned) begin
                        state_d      = COMPLETE;
                        data_abort_d = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        d_access_d  = 1'b1;
                        d_addr_d    = {mar[31:2], 2'b00};
                        d_bytesel_d = bytesel;
                        d_wr_en_d   = mem_store;
                        d_wr_val_d  = store_val;
                    end
                end else begin
                    reg_wr_en_d  = wr_result;
                    reg_wr_sel_d = rd_sel;
                    reg_wr_val_d = wr_val;
                end
            end
            ACCESS: begin
                busy = 1'b1;
                // Bus error wins over a simultaneous acknowledge.
                if (d_error) begin
                    state_d      = COMPLETE;
                    d_access_d   = 1'b0;
                    d_wr_en_d    = 1'b0;
                    data_abort_d = 1'b1;
                end else if (d_ack) begin
                    state_d      = COMPLETE;
                    d_access_d   = 1'b0;
                    d_wr_en_d    = 1'b0;
                    reg_wr_en_d  = mem_load & wr_result;
                    reg_wr_sel_d = rd_sel;
                    reg_wr_val_d = load_val;
                end
            end
            COMPLETE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here to match the rest of the pipeline; all state, data included, is cleared.
        if (rst) begin
            state_q      <= IDLE;
            d_access_q   <= 1'b0;
            d_addr_q     <= 32'd0;
            d_bytesel_q  <= 4'd0;
            d_wr_en_q    <= 1'b0;
            d_wr_val_q   <= 32'd0;
            data_abort_q <= 1'b0;
            reg_wr_en_q  <= 1'b0;
            reg_wr_sel_q <= 4'd0;
            reg_wr_val_q <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            d_access_q   <= d_access_d;
            d_addr_q     <= d_addr_d;
            d_bytesel_q  <= d_bytesel_d;
            d_wr_en_q    <= d_wr_en_d;
            d_wr_val_q   <= d_wr_val_d;
            data_abort_q <= data_abort_d;
            reg_wr_en_q  <= reg_wr_en_d;
            reg_wr_sel_q <= reg_wr_sel_d;
            reg_wr_val_q <= reg_wr_val_d;
        end
    end

    assign d_access   = d_access_q;
    assign d_addr     = d_addr_q;
    assign d_bytesel  = d_bytesel_q;
    assign d_wr_en    = d_wr_en_q;
    assign d_wr_val   = d_wr_val_q;
    assign data_abort = data_abort_q;
    assign reg_wr_en  = reg_wr_en_q;
    assign reg_wr_sel = reg_wr_sel_q;
    assign reg_wr_val = reg_wr_val_q;

endmodule
